// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access stage and the load-extraction stage.
package mem_pkg;

    localparam logic [1:0] MB_WORD = 2'b00;
    localparam logic [1:0] MB_HALF = 2'b10;
    localparam logic [1:0] MB_BYTE = 2'b11;

    localparam int unsigned TIMEOUT_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-enable generation, store-data lane replication and alignment check.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  byte_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic        misalign_o
);

    always_comb begin
        be_o       = 4'b1111;
        wdata_o    = wdata_i;
        misalign_o = 1'b0;
        case (byte_i)
            MB_HALF: begin
                be_o       = addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_o    = {2{wdata_i[15:0]}};
                misalign_o = addr_i[0];
            end
            MB_BYTE: begin
                be_o    = 4'b0001 << addr_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            default: begin
                // 00 and 01 both encode a word access
                misalign_o = (addr_i != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store stage: alignment check, handshaked word bus request,
// bus-ack timeout and registered raw load result for the extraction stage.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_byte,
    input  logic        req_sign,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        ld_valid,
    output logic [31:0] ld_data,
    output logic [1:0]  ld_addr,
    output logic [1:0]  ld_byte,
    output logic        ld_sign
);

    mem_state_e  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        ld_valid_q, ld_valid_d;
    logic [31:0] ld_data_q, ld_data_d;
    logic [1:0]  ld_addr_q, ld_addr_d;
    logic [1:0]  ld_byte_q, ld_byte_d;
    logic        ld_sign_q, ld_sign_d;

    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic        al_mis;

    mem_lane_align u_align (
        .byte_i     (req_byte),
        .addr_i     (req_addr[1:0]),
        .wdata_i    (req_wdata),
        .be_o       (al_be),
        .wdata_o    (al_wdata),
        .misalign_o (al_mis)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ld_valid_q  <= 1'b0;
            ld_data_q   <= '0;
            ld_addr_q   <= '0;
            ld_byte_q   <= '0;
            ld_sign_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
            ld_valid_q  <= ld_valid_d;
            ld_data_q   <= ld_data_d;
            ld_addr_q   <= ld_addr_d;
            ld_byte_q   <= ld_byte_d;
            ld_sign_q   <= ld_sign_d;
        end
    end

    // Outputs are computed for the state being entered, so they are registered
    // yet line up with that state (done/err/ld_valid high exactly during RESP).
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        ld_valid_d  = 1'b0;
        ld_data_d   = ld_data_q;
        ld_addr_d   = ld_addr_q;
        ld_byte_d   = ld_byte_q;
        ld_sign_d   = ld_sign_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (al_mis) begin
                        state_d = ST_RESP;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d     = ST_BUS;
                        cnt_d       = '0;
                        bus_req_d   = 1'b1;
                        bus_we_d    = req_write;
                        bus_addr_d  = {req_addr[31:2], 2'b00};
                        bus_be_d    = al_be;
                        bus_wdata_d = al_wdata;
                        if (!req_write) begin
                            ld_addr_d = req_addr[1:0];
                            ld_byte_d = req_byte;
                            ld_sign_d = req_sign;
                        end
                    end
                end
            end
            ST_BUS: begin
                if (bus_ack) begin
                    state_d   = ST_RESP;
                    bus_req_d = 1'b0;
                    done_d    = 1'b1;
                    if (!bus_we_q) begin
                        ld_valid_d = 1'b1;
                        ld_data_d  = bus_rdata;
                    end
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    state_d   = ST_RESP;
                    bus_req_d = 1'b0;
                    done_d    = 1'b1;
                    err_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    assign stall     = ((state_q == ST_IDLE) && req_valid && !al_mis) || (state_q == ST_BUS);
    assign done      = done_q;
    assign err       = err_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;
    assign ld_valid  = ld_valid_q;
    assign ld_data   = ld_data_q;
    assign ld_addr   = ld_addr_q;
    assign ld_byte   = ld_byte_q;
    assign ld_sign   = ld_sign_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed table, random transactions, reset abort.
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_byte = 2'b00;
    logic        req_sign = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        stall, done, err;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic [1:0]  ld_addr, ld_byte;
    logic        ld_sign;

    int errors = 0;
    int checks = 0;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_byte  (req_byte),
        .req_sign  (req_sign),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .stall     (stall),
        .done      (done),
        .err       (err),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_addr   (ld_addr),
        .ld_byte   (ld_byte),
        .ld_sign   (ld_sign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: access width in bytes, natural alignment, lane placement.
    function automatic int nbytes(input logic [1:0] sz);
        if (sz == 2'b11) return 1;
        if (sz == 2'b10) return 2;
        return 4;
    endfunction

    function automatic logic model_mis(input logic [1:0] sz, input logic [31:0] a);
        return (a % nbytes(sz)) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
        int n = nbytes(sz);
        int m = (1 << n) - 1;
        return 4'(m << (a % 4));
    endfunction

    function automatic logic [31:0] model_wd(input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] r = '0;
        int n = nbytes(sz);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
        return r;
    endfunction

    // delay = number of BUS cycles without ack before ack; delay >= TO means never ack.
    task automatic run_txn(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                           input logic [31:0] wd, input logic sgn, input int delay,
                           input logic [31:0] rdata, input logic [3:0] e_be,
                           input logic [31:0] e_wd, input logic e_mis);
        logic timed_out;
        logic acked;
        req_valid = 1'b1;
        req_write = wr;
        req_byte  = sz;
        req_addr  = addr;
        req_wdata = wd;
        req_sign  = sgn;
        #1;
        chk("accept_stall", 32'(stall), 32'(!e_mis));
        tick();
        if (e_mis) begin
            chk("mis_done", 32'(done), 32'd1);
            chk("mis_err", 32'(err), 32'd1);
            chk("mis_bus_req", 32'(bus_req), 32'd0);
            chk("mis_stall", 32'(stall), 32'd0);
            chk("mis_ld_valid", 32'(ld_valid), 32'd0);
            req_valid = 1'b0;
            tick();
            chk("mis_done_clear", 32'(done), 32'd0);
            return;
        end
        timed_out = 1'b0;
        acked = 1'b0;
        for (int k = 0; k < TO; k++) begin
            chk("bus_req", 32'(bus_req), 32'd1);
            chk("bus_stall", 32'(stall), 32'd1);
            chk("bus_we", 32'(bus_we), 32'(wr));
            chk("bus_addr", bus_addr, {addr[31:2], 2'b00});
            chk("bus_be", 32'(bus_be), 32'(e_be));
            chk("bus_wdata", bus_wdata, e_wd);
            chk("bus_done_low", 32'(done), 32'd0);
            if (k == delay) begin
                bus_ack = 1'b1;
                bus_rdata = rdata;
                acked = 1'b1;
            end
            tick();
            bus_ack = 1'b0;
            bus_rdata = $urandom;
            if (acked) break;
        end
        if (!acked) timed_out = 1'b1;
        chk("resp_done", 32'(done), 32'd1);
        chk("resp_err", 32'(err), 32'(timed_out));
        chk("resp_ld_valid", 32'(ld_valid), 32'(!wr && !timed_out));
        chk("resp_bus_req", 32'(bus_req), 32'd0);
        chk("resp_stall", 32'(stall), 32'd0);
        if (!wr && !timed_out) begin
            chk("ld_data", ld_data, rdata);
            chk("ld_addr", 32'(ld_addr), 32'(addr[1:0]));
            chk("ld_byte", 32'(ld_byte), 32'(sz));
            chk("ld_sign", 32'(ld_sign), 32'(sgn));
        end
        req_valid = 1'b0;
        tick();
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_ld_valid", 32'(ld_valid), 32'd0);
    endtask

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        sgn;
        int          delay;
        logic [31:0] rdata;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        logic        e_mis;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b0, 2'b00, 32'h0000_0100, 32'h0,         1'b0, 0,  32'hDEAD_BEEF, 4'b1111, 32'h0000_0000, 1'b0};
        vecs[1] = '{1'b1, 2'b11, 32'h0000_0203, 32'h0000_00A5, 1'b0, 3,  32'h0,         4'b1000, 32'hA5A5_A5A5, 1'b0};
        vecs[2] = '{1'b0, 2'b10, 32'h0000_0006, 32'h0,         1'b1, 1,  32'h1234_5678, 4'b1100, 32'h0000_0000, 1'b0};
        vecs[3] = '{1'b0, 2'b10, 32'h0000_0001, 32'h0,         1'b0, 0,  32'h0,         4'b0000, 32'h0000_0000, 1'b1};
        vecs[4] = '{1'b1, 2'b00, 32'h0000_0002, 32'h1111_2222, 1'b0, 0,  32'h0,         4'b0000, 32'h0000_0000, 1'b1};
        vecs[5] = '{1'b0, 2'b00, 32'h0000_0040, 32'h0,         1'b0, TO, 32'h0,         4'b1111, 32'h0000_0000, 1'b0};
        vecs[6] = '{1'b1, 2'b10, 32'h0000_0010, 32'h1234_BEEF, 1'b0, 2,  32'h0,         4'b0011, 32'hBEEF_BEEF, 1'b0};
        vecs[7] = '{1'b1, 2'b01, 32'h0000_0008, 32'hCAFE_F00D, 1'b0, 0,  32'h0,         4'b1111, 32'hCAFE_F00D, 1'b0};

        #3;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_bus_be", 32'(bus_be), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_ld_valid", 32'(ld_valid), 32'd0);
        chk("rst_ld_data", ld_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].wr, vecs[i].sz, vecs[i].addr, vecs[i].wd, vecs[i].sgn,
                    vecs[i].delay, vecs[i].rdata, vecs[i].e_be, vecs[i].e_wd, vecs[i].e_mis);
        end

        // Ack outside BUS must be ignored.
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        chk("stray_ack_done", 32'(done), 32'd0);
        chk("stray_ack_bus_req", 32'(bus_req), 32'd0);

        // Reset in the middle of BUS aborts without a done pulse.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_byte  = 2'b00;
        req_addr  = 32'h0000_0300;
        tick();
        tick();
        chk("pre_abort_bus_req", 32'(bus_req), 32'd1);
        #2;
        rst_n = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("abort_bus_req", 32'(bus_req), 32'd0);
        chk("abort_stall", 32'(stall), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_abort_done", 32'(done), 32'd0);
        run_txn(1'b0, 2'b00, 32'h0000_0300, 32'h0, 1'b0, 1, 32'h5A5A_0F0F,
                4'b1111, 32'h0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic        wr;
            logic [1:0]  sz;
            logic [31:0] addr, wd, rd;
            logic        sgn;
            int          dly;
            wr   = 1'($urandom);
            sz   = 2'($urandom);
            addr = $urandom;
            wd   = $urandom;
            rd   = $urandom;
            sgn  = 1'($urandom);
            dly  = int'($urandom_range(0, TO));
            run_txn(wr, sz, addr, wd, sgn, dly, rd,
                    model_be(sz, addr), model_wd(sz, wd), model_mis(sz, addr));
            if ($urandom_range(0, 3) == 0) begin
                bus_ack = 1'b1;
                tick();
                bus_ack = 1'b0;
                chk("rand_stray_ack", 32'(done), 32'd0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Multi-cycle data-memory access stage that sits between the CPU's execute/memory control and a handshaked word-wide data bus. It directly feeds the load-extraction stage. It accepts one load or store per transaction and checks alignment. It converts the transaction into a word-aligned bus request with byte enables and lane-replicated write data, and stalls the CPU until the bus acknowledges or a timeout fires. For loads it registers the raw bus word together with `addr[1:0]`, size and sign, so the extraction stage can select and extend the addressed field.

## Interface
- `TIMEOUT`, default 16: maximum cycles spent in BUS waiting for `bus_ack`, valid range 2..255.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: CPU presents a memory operation this cycle.
- `req_write` in 1: 1 = store, 0 = load.
- `req_byte` in 2: size; 10 = half, 11 = byte, 00/01 = word.
- `req_sign` in 1: load sign-extension flag, passed through.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `stall` out 1: CPU must hold its request and pipeline.
- `done` out 1: one-cycle pulse, transaction finished.
- `err` out 1: one-cycle pulse with `done`, for a misaligned access or a timeout.
- `bus_req` out 1: bus request, held until acknowledged.
- `bus_we` out 1: bus write.
- `bus_addr` out 32: `{req_addr[31:2], 2'b00}`.
- `bus_be` out 4: byte enables.
- `bus_wdata` out 32: lane-replicated store data.
- `bus_ack` in 1: bus completes the request this cycle.
- `bus_rdata` in 32: read word, valid when `bus_ack` is high.
- `ld_valid` out 1: one-cycle pulse, load result fields are valid.
- `ld_data` out 32: raw bus word.
- `ld_addr` out 2: latched `req_addr[1:0]`.
- `ld_byte` out 2: latched `req_byte`.
- `ld_sign` out 1: latched `req_sign`.

## Operation
- FSM states are IDLE, BUS and RESP.
- **Alignment check:** an access is misaligned when it is a half with `addr[0]`=1, or a word with `addr[1:0]`≠0. Bytes are never misaligned.
- **IDLE, misaligned request:** on `req_valid` with a misaligned access, go to RESP with `err`=1 and no bus activity.
- **IDLE, aligned request:** on `req_valid` with an aligned access, latch the request and go to BUS. The counter is cleared.
- **Byte enables:**
  - word: 1111.
  - half: 0011 when `addr[1]`=0, otherwise 1100.
  - byte: `4'b0001 << addr[1:0]`.
- **Write data:**
  - word: `req_wdata`.
  - half: `{2{req_wdata[15:0]}}`.
  - byte: `{4{req_wdata[7:0]}}`.
- **BUS:**
  - `bus_req`=1 and all bus outputs are held stable.
  - On `bus_ack`, go to RESP. For a load, capture `bus_rdata` into `ld_data` in the same edge.
  - With no ack, the counter increments. When the counter reaches `TIMEOUT-1` without an ack, go to RESP with `err`=1 and drop `bus_req`.
- **RESP:** `done`=1. `ld_valid`=1 only for a successful load. Return to IDLE unconditionally.
- `bus_ack` seen outside BUS is ignored. `req_valid` in BUS or RESP is ignored.

## Timing
- **Reset values:** all outputs are 0 (`bus_be` 0000, `ld_*` 0) and the state is IDLE. Reset asserted mid-transaction aborts it immediately; no `done` is produced.
- **Output registering:** `bus_*`, `done`, `err`, `ld_*` are registered from state. `stall` is combinational and equals (IDLE & `req_valid` & aligned) | BUS.
- **Minimum latency:** accept in cycle 0, `bus_req` in cycle 1 with a same-cycle `bus_ack`, then `done`/`ld_valid` in cycle 2.
- **Misaligned path:** `done`+`err` in cycle 1, with `stall` low throughout.
- **Timeout path:** `bus_req` is high for exactly `TIMEOUT` cycles, then `done`+`err` in the following cycle.
- **Back-to-back:** a new request is accepted in the cycle after RESP at the earliest.

## Structure
- **Package `mem_pkg`:**
  - size encodings `MB_WORD`/`MB_HALF`/`MB_BYTE`;
  - the state enum;
  - the default `TIMEOUT`.
  - The extraction stage shares the same size encodings.
- **Sub-module `mem_lane_align`:** combinational; inputs are size, `addr[1:0]` and wdata; outputs are `be`, replicated wdata and the misaligned flag.

## Test plan
- **Aligned word load at 0x100, ack on first BUS cycle, rdata 0xDEADBEEF:** `bus_be`=1111 and `bus_addr`=0x100. Two cycles after accept, `ld_valid`=1, `ld_data`=0xDEADBEEF, `ld_addr`=00.
- **Byte store 0xA5 to 0x203, ack after 3 wait cycles:** `bus_addr`=0x200, `bus_be`=1000, `bus_wdata`=0xA5A5A5A5. `stall` stays high for 5 cycles, then `done`=1 with `ld_valid`=0.
- **Half load at 0x0000_0006 with sign=1:** `bus_be`=1100. `ld_addr`=10, `ld_byte`=10, `ld_sign`=1.
- **Misaligned half at 0x0000_0001 and word at 0x0000_0002:** each gives `done`=`err`=1 one cycle later, `bus_req` never rises, `stall`=0.
- **No ack with `TIMEOUT`=4:** `bus_req` is high 4 cycles, then `done`=`err`=1 and `ld_valid`=0.
- **`rst_n` pulled low while in BUS:** `bus_req` and `stall` drop asynchronously. After release, a fresh word load completes normally.
